// File: rtl/imm_encoder_if.sv
// Request/response bundle for imm_encoder: immediate + base word in, merged instruction out.
interface imm_encoder_if #(
   parameter int unsigned CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_imm;
   logic [2:0]       in_imm_src;
   logic [31:0]      in_base;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_instr;
   logic             out_err;
   logic [CNT_W-1:0] enc_count;

   modport master (
      output in_valid, in_imm, in_imm_src, in_base, out_ready,
      input  in_ready, out_valid, out_instr, out_err, enc_count
   );

   modport slave (
      input  in_valid, in_imm, in_imm_src, in_base, out_ready,
      output in_ready, out_valid, out_instr, out_err, enc_count
   );
endinterface

// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into I/S/B/U/J fields of a base instruction; 2-stage valid/ready pipe.
// Optional range/unsupported-source flagging on out_err: define IMM_ENCODER_RANGE_CHECK_EN.
module imm_encoder #(
   parameter int unsigned CNT_W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   imm_encoder_if.slave bus
);
   localparam logic [2:0] SRC_I = 3'd0;
   localparam logic [2:0] SRC_S = 3'd1;
   localparam logic [2:0] SRC_B = 3'd2;
   localparam logic [2:0] SRC_U = 3'd3;
   localparam logic [2:0] SRC_J = 3'd4;

   logic             s1_v_q;
   logic [31:0]      s1_imm_q;
   logic [2:0]       s1_src_q;
   logic [31:0]      s1_base_q;
   logic             s2_v_q;
   logic [31:0]      s2_instr_q;
   logic             s2_err_q;
   logic [CNT_W-1:0] cnt_q;

   logic             s2_adv_c;
   logic             in_ready_c;
   logic             in_fire_c;
   logic             out_fire_c;
   logic [31:0]      instr_d;
   logic             err_d;
   logic [CNT_W-1:0] cnt_d;

   assign s2_adv_c   = s1_v_q && (!s2_v_q || bus.out_ready);
   assign in_ready_c = !s1_v_q || s2_adv_c;
   assign in_fire_c  = bus.in_valid && in_ready_c;
   assign out_fire_c = s2_v_q && bus.out_ready;
   assign cnt_d      = out_fire_c ? cnt_q + CNT_W'(1) : cnt_q;

   // Field packing; bits outside the selected immediate field come from the base word.
   always_comb begin
      instr_d = s1_base_q;
      case (s1_src_q)
         SRC_I: instr_d[31:20] = s1_imm_q[11:0];
         SRC_S: begin
            instr_d[31:25] = s1_imm_q[11:5];
            instr_d[11:7]  = s1_imm_q[4:0];
         end
         SRC_B: begin
            instr_d[31]    = s1_imm_q[12];
            instr_d[7]     = s1_imm_q[11];
            instr_d[30:25] = s1_imm_q[10:5];
            instr_d[11:8]  = s1_imm_q[4:1];
         end
         SRC_U: instr_d[31:12] = s1_imm_q[19:0];
         SRC_J: begin
            instr_d[31]    = s1_imm_q[20];
            instr_d[19:12] = s1_imm_q[19:12];
            instr_d[20]    = s1_imm_q[11];
            instr_d[30:21] = s1_imm_q[10:1];
         end
         default: ;
      endcase
   end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
   logic is_ok_c;
   logic bs_ok_c;
   logic u_ok_c;
   logic j_ok_c;

   // A field is representable when every bit above it repeats the sign bit.
   assign is_ok_c = (&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]);
   assign bs_ok_c = ((&s1_imm_q[31:12]) || !(|s1_imm_q[31:12])) && !s1_imm_q[0];
   assign u_ok_c  = (&s1_imm_q[31:19]) || !(|s1_imm_q[31:19]);
   assign j_ok_c  = ((&s1_imm_q[31:20]) || !(|s1_imm_q[31:20])) && !s1_imm_q[0];

   always_comb begin
      err_d = 1'b1;
      case (s1_src_q)
         SRC_I, SRC_S: err_d = !is_ok_c;
         SRC_B:        err_d = !bs_ok_c;
         SRC_U:        err_d = !u_ok_c;
         SRC_J:        err_d = !j_ok_c;
         default:      err_d = 1'b1;
      endcase
   end
`else
   logic unused_imm_hi;

   assign unused_imm_hi = ^s1_imm_q[31:21];
   assign err_d         = 1'b0;
`endif

   // Stage 1: capture request on input handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q    <= 1'b0;
         s1_imm_q  <= 32'h0;
         s1_src_q  <= 3'h0;
         s1_base_q <= 32'h0;
      end else if (in_fire_c) begin
         s1_v_q    <= 1'b1;
         s1_imm_q  <= bus.in_imm;
         s1_src_q  <= bus.in_imm_src;
         s1_base_q <= bus.in_base;
      end else if (s2_adv_c) begin
         s1_v_q    <= 1'b0;
      end
   end

   // Stage 2: merged word and error; held while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v_q     <= 1'b0;
         s2_instr_q <= 32'h0;
         s2_err_q   <= 1'b0;
      end else if (s2_adv_c) begin
         s2_v_q     <= 1'b1;
         s2_instr_q <= instr_d;
         s2_err_q   <= err_d;
      end else if (out_fire_c) begin
         s2_v_q     <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = s2_v_q;
   assign bus.out_instr = s2_instr_q;
   assign bus.out_err   = s2_err_q;
   assign bus.enc_count = cnt_q;
endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder (4-bit counter so wrap is exercised).
module tb_imm_encoder;
   localparam int unsigned CNT_W = 4;
`ifdef IMM_ENCODER_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   imm_encoder_if #(.CNT_W(CNT_W)) bus ();
   imm_encoder #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.in_imm = 32'h0; bus.in_imm_src = 3'h0;
      bus.in_base = 32'h0; bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got=%h exp=0", bus.out_instr); end
      checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got=%b exp=0", bus.out_err); end
      checks++; if (bus.enc_count !== 4'd0) begin errors++; $display("FAIL reset_enc_count got=%0d exp=0", bus.enc_count); end
   endtask

   task automatic test_fields();
      logic [31:0] t_imm  [10];
      logic [2:0]  t_src  [10];
      logic [31:0] t_base [10];
      logic [31:0] t_exp  [10];
      logic        t_err  [10];
      logic        exp_err;
      t_imm[0]=32'hFFFF_F800; t_src[0]=3'd0; t_base[0]=32'h0000_0013; t_exp[0]=32'h8000_0013; t_err[0]=1'b0;
      t_imm[1]=32'h0000_07FF; t_src[1]=3'd1; t_base[1]=32'h0000_2023; t_exp[1]=32'h7E00_2FA3; t_err[1]=1'b0;
      t_imm[2]=32'hFFFF_FFFE; t_src[2]=3'd2; t_base[2]=32'h0000_0063; t_exp[2]=32'hFE00_0FE3; t_err[2]=1'b0;
      t_imm[3]=32'h0010_0001; t_src[3]=3'd4; t_base[3]=32'h0000_006F; t_exp[3]=32'h8000_006F; t_err[3]=1'b1;
      t_imm[4]=32'h0008_0000; t_src[4]=3'd3; t_base[4]=32'h0000_0037; t_exp[4]=32'h8000_0037; t_err[4]=1'b1;
      t_imm[5]=32'h0007_FFFF; t_src[5]=3'd3; t_base[5]=32'h0000_0037; t_exp[5]=32'h7FFF_F037; t_err[5]=1'b0;
      t_imm[6]=32'h000F_FFFE; t_src[6]=3'd4; t_base[6]=32'h0000_006F; t_exp[6]=32'h7FFF_F06F; t_err[6]=1'b0;
      t_imm[7]=32'hFFFF_FFFF; t_src[7]=3'd5; t_base[7]=32'h1234_5678; t_exp[7]=32'h1234_5678; t_err[7]=1'b1;
      t_imm[8]=32'h0000_0800; t_src[8]=3'd0; t_base[8]=32'h0000_0013; t_exp[8]=32'h8000_0013; t_err[8]=1'b1;
      t_imm[9]=32'h0000_0003; t_src[9]=3'd2; t_base[9]=32'h0000_0063; t_exp[9]=32'h0000_0163; t_err[9]=1'b1;
      for (int i = 0; i < 10; i++) begin
         exp_err = RC & t_err[i];
         @(negedge clk);
         bus.out_ready = 1'b0;
         bus.in_valid = 1'b1; bus.in_imm = t_imm[i]; bus.in_imm_src = t_src[i]; bus.in_base = t_base[i];
         #1;
         checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL field%0d_in_ready got=%b exp=1", i, bus.in_ready); end
         @(negedge clk);
         bus.in_valid = 1'b0; bus.in_imm = 32'hDEAD_BEEF; bus.in_base = 32'hFFFF_FFFF;
         checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL field%0d_latency1 out_valid got=%b exp=0", i, bus.out_valid); end
         @(negedge clk);
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL field%0d_latency2 out_valid got=%b exp=1", i, bus.out_valid); end
         checks++; if (bus.out_instr !== t_exp[i]) begin errors++; $display("FAIL field%0d_instr got=%h exp=%h", i, bus.out_instr, t_exp[i]); end
         checks++; if (bus.out_err !== exp_err) begin errors++; $display("FAIL field%0d_err got=%b exp=%b", i, bus.out_err, exp_err); end
         @(negedge clk);
         checks++; if (bus.out_instr !== t_exp[i] || bus.out_valid !== 1'b1) begin errors++; $display("FAIL field%0d_stall_hold got=%h/%b exp=%h/1", i, bus.out_instr, bus.out_valid, t_exp[i]); end
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.out_ready = 1'b0;
         checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL field%0d_drain out_valid got=%b exp=0", i, bus.out_valid); end
      end
      checks++; if (bus.enc_count !== 4'd10) begin errors++; $display("FAIL fields_enc_count got=%0d exp=10", bus.enc_count); end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_w [8];
      int sent, recv, occ;
      logic pat [4];
      logic prev_v, prev_r, exp_rdy, in_fire, out_fire;
      logic [31:0] prev_i;
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      for (int i = 0; i < 8; i++) exp_w[i] = {12'(i * 32'h111), 20'h00013};
      apply_reset();
      sent = 0; recv = 0; prev_v = 1'b0; prev_r = 1'b0; prev_i = 32'h0;
      for (int cyc = 0; cyc < 100 && recv < 8; cyc++) begin
         @(negedge clk);
         bus.out_ready = pat[cyc % 4];
         bus.in_valid  = (sent < 8);
         bus.in_imm    = (sent < 8) ? (32'(sent) * 32'h111) & 32'h7FF : 32'h0;
         bus.in_imm_src = 3'd0; bus.in_base = 32'h0000_0013;
         #1;
         occ = sent - recv;
         exp_rdy = !(occ == 2 && !bus.out_ready);
         checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b occ=%0d", cyc, bus.in_ready, exp_rdy, occ); end
         if (prev_v && !prev_r) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== prev_i) begin errors++; $display("FAIL bp_stall_hold cyc=%0d got=%h/%b exp=%h/1", cyc, bus.out_instr, bus.out_valid, prev_i); end
         end
         in_fire  = bus.in_valid && bus.in_ready;
         out_fire = bus.out_valid && bus.out_ready;
         if (out_fire) begin
            checks++; if (bus.out_instr !== exp_w[recv]) begin errors++; $display("FAIL bp_word%0d got=%h exp=%h", recv, bus.out_instr, exp_w[recv]); end
         end
         prev_v = bus.out_valid; prev_r = bus.out_ready; prev_i = bus.out_instr;
         @(posedge clk);
         if (in_fire) sent++;
         if (out_fire) recv++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      checks++; if (recv != 8) begin errors++; $display("FAIL bp_received got=%0d exp=8", recv); end
      checks++; if (bus.enc_count !== 4'd8) begin errors++; $display("FAIL bp_enc_count got=%0d exp=8", bus.enc_count); end
   endtask

   task automatic test_back_to_back();
      int sent, recv, gaps;
      logic started, wrap_seen, in_fire, out_fire;
      logic [3:0] prev_cnt;
      logic [31:0] exp_i;
      apply_reset();
      sent = 0; recv = 0; gaps = 0; started = 1'b0; wrap_seen = 1'b0; prev_cnt = 4'd0;
      for (int cyc = 0; cyc < 200 && recv < 100; cyc++) begin
         @(negedge clk);
         bus.out_ready = 1'b1;
         bus.in_valid  = (sent < 100);
         bus.in_imm    = 32'(sent); bus.in_imm_src = 3'd0; bus.in_base = 32'h0000_0013;
         #1;
         if (prev_cnt == 4'd15 && bus.enc_count == 4'd0) wrap_seen = 1'b1;
         prev_cnt = bus.enc_count;
         if (started && !bus.out_valid) gaps++;
         if (bus.out_valid) begin
            started = 1'b1;
            exp_i = {12'(recv), 20'h00013};
            checks++; if (bus.out_instr !== exp_i) begin errors++; $display("FAIL b2b_word%0d got=%h exp=%h", recv, bus.out_instr, exp_i); end
         end
         in_fire  = bus.in_valid && bus.in_ready;
         out_fire = bus.out_valid && bus.out_ready;
         @(posedge clk);
         if (in_fire) sent++;
         if (out_fire) recv++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (prev_cnt == 4'd15 && bus.enc_count == 4'd0) wrap_seen = 1'b1;
      checks++; if (recv != 100) begin errors++; $display("FAIL b2b_received got=%0d exp=100", recv); end
      checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_bubbles got=%0d exp=0", gaps); end
      checks++; if (bus.enc_count !== 4'd4) begin errors++; $display("FAIL b2b_enc_count got=%0d exp=4", bus.enc_count); end
      checks++; if (!wrap_seen) begin errors++; $display("FAIL b2b_wrap got=0 exp=1"); end
   endtask

   task automatic test_reset_midflight();
      int stale;
      @(negedge clk);
      bus.out_ready = 1'b0; bus.in_valid = 1'b1;
      bus.in_imm = 32'h0000_0123; bus.in_imm_src = 3'd0; bus.in_base = 32'h0000_0013;
      @(negedge clk);
      bus.in_imm = 32'h0000_0456;
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_fill got=v%b/r%b exp=v1/r0", bus.out_valid, bus.in_ready); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.enc_count !== 4'd0) begin errors++; $display("FAIL rst_async_enc_count got=%0d exp=0", bus.enc_count); end
      checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL rst_async_out_instr got=%h exp=0", bus.out_instr); end
      @(negedge clk);
      rst_n = 1'b1; bus.out_ready = 1'b1;
      stale = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) stale++;
      end
      checks++; if (stale != 0) begin errors++; $display("FAIL rst_stale_words got=%0d exp=0", stale); end
      checks++; if (bus.enc_count !== 4'd0) begin errors++; $display("FAIL rst_enc_count got=%0d exp=0", bus.enc_count); end
   endtask

   initial begin
      checks = 0; errors = 0;
      test_reset();
      test_fields();
      test_backpressure();
      test_back_to_back();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
